// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM state codes and default widths.
package axi4_lite_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Master FSM encoding, kept as plain constants so older tooling can share it.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_RSP   = 3'd5;

endpackage

// File: rtl/axi4_lite_master_wdog.sv
// Transaction watchdog for axi4_lite_master: counts busy cycles and raises a sticky flag.
module axi4_lite_master_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clear,
  input  logic active,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Counter saturates at LIMIT so a hung slave cannot wrap it back to zero.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      count_reg <= '0;
      timeout   <= 1'b0;
    end else begin
      if (clear) begin
        count_reg <= '0;
      end else if (active && (count_reg != LIMIT)) begin
        count_reg <= count_reg + 1'b1;
      end
      if (active && !clear && (count_reg == LIMIT)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master behind a valid/ready command/response port.
// Optional watchdog enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS        = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDRESS-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_TIMEOUT,
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  localparam logic [ADDRESS-1:0] ADDR_ALIGN_MASK = {{(ADDRESS-2){1'b1}}, 2'b00};

  logic [2:0]         state_reg;
  logic               cmd_fire;
  logic               aw_done;
  logic               w_done;
  logic [ADDRESS-1:0] cmd_addr_aligned;

  assign cmd_fire         = CMD_VALID && CMD_READY;
  assign cmd_addr_aligned = CMD_ADDR & ADDR_ALIGN_MASK;
  // A channel is done once its VALID is gone or its handshake lands this cycle.
  assign aw_done          = !M_AWVALID || M_AWREADY;
  assign w_done           = !M_WVALID || M_WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= ST_IDLE;
      CMD_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_RESP  <= RESP_OKAY;
      M_AWADDR  <= '0;
      M_AWVALID <= 1'b0;
      M_WDATA   <= '0;
      M_WSTRB   <= '0;
      M_WVALID  <= 1'b0;
      M_BREADY  <= 1'b0;
      M_ARADDR  <= '0;
      M_ARVALID <= 1'b0;
      M_RREADY  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_fire) begin
            CMD_READY <= 1'b0;
            if (CMD_WRITE) begin
              M_AWADDR  <= cmd_addr_aligned;
              M_WDATA   <= CMD_WDATA;
              M_WSTRB   <= CMD_WSTRB;
              M_AWVALID <= 1'b1;
              M_WVALID  <= 1'b1;
              state_reg <= ST_WRITE;
            end else begin
              M_ARADDR  <= cmd_addr_aligned;
              M_ARVALID <= 1'b1;
              state_reg <= ST_RADDR;
            end
          end
        end
        ST_WRITE: begin
          if (M_AWVALID && M_AWREADY) M_AWVALID <= 1'b0;
          if (M_WVALID && M_WREADY)   M_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            M_BREADY  <= 1'b1;
            state_reg <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (M_BVALID && M_BREADY) begin
            M_BREADY  <= 1'b0;
            RSP_RESP  <= M_BRESP;
            RSP_RDATA <= '0;
            RSP_VALID <= 1'b1;
            state_reg <= ST_RSP;
          end
        end
        ST_RADDR: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state_reg <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (M_RVALID && M_RREADY) begin
            M_RREADY  <= 1'b0;
            RSP_RDATA <= M_RDATA;
            RSP_RESP  <= M_RRESP;
            RSP_VALID <= 1'b1;
            state_reg <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  logic wdog_active;

  // The response phase waits on our own client, not the slave, so it is not timed.
  assign wdog_active = (state_reg != ST_IDLE) && (state_reg != ST_RSP);

  axi4_lite_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clear  (cmd_fire),
    .active (wdog_active),
    .timeout(RSP_TIMEOUT)
  );
`else
  assign RSP_TIMEOUT = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule
